// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester round-robin access arbiter and zero-fill
// clear sequencer in front of a 16 x 32-bit single-write-port register file.
//
// Optional build macro: REGFILE_ARB_R0_ZERO_EN -- register 0 hardwired to zero
// (writes to address 0 are accepted but suppressed, reads of address 0 return 0).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   clr_req / clr_busy    start a zero-fill of registers 1..15 / fill in progress
//   rN_req/we/addr/wdata  requester N access (N = 0 core datapath, 1 debug/load)
//   rN_gnt                combinational grant, access accepted at end of cycle
//   rN_rvalid / rN_rdata  read return, two cycles after the grant
//   rf_*                  register file read/write port (rf_readdata in)
module regfile_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] rf_readreg,
  output logic [ADDR_W-1:0] rf_writereg,
  output logic [DATA_W-1:0] rf_writedata,
  output logic              rf_write_en,
  input  logic [DATA_W-1:0] rf_readdata
);

  localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CLR_LAST  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              last_gnt;   // id of the requester granted most recently

  // Read tag pipeline: stage 1 = rf_readreg presented, stage 2 = rf_readdata valid
  logic s1_rd, s1_id, s1_zero;
  logic s2_rd, s2_id, s2_zero;

  logic              can_grant;
  logic              gnt0, gnt1, any_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_zero;

  // Grant decision: round-robin on a tie, lone requester always wins
  always_comb begin
    can_grant = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    can_grant = !reset && (state == IDLE) && !clr_req;
    gnt0      = can_grant && r0_req && (!r1_req || last_gnt);
    gnt1      = can_grant && r1_req && (!r0_req || !last_gnt);
  end

  // Winner's access fields
  always_comb begin
    any_gnt   = gnt0 | gnt1;
    win_we    = gnt1 ? r1_we    : r0_we;
    win_addr  = gnt1 ? r1_addr  : r0_addr;
    win_wdata = gnt1 ? r1_wdata : r0_wdata;
`ifdef REGFILE_ARB_R0_ZERO_EN
    win_zero  = (win_addr == '0);
`else
    win_zero  = 1'b0;
`endif
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  // State, clear counter, pointer, tag pipeline and registered rf port
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      clr_busy     <= 1'b0;
      clr_cnt      <= '0;
      last_gnt     <= 1'b1;
      s1_rd        <= 1'b0;
      s1_id        <= 1'b0;
      s1_zero      <= 1'b0;
      s2_rd        <= 1'b0;
      s2_id        <= 1'b0;
      s2_zero      <= 1'b0;
      rf_write_en  <= 1'b0;
      rf_readreg   <= '0;
      rf_writereg  <= '0;
      rf_writedata <= '0;
    end else begin
      // Tags keep moving in every state so reads in flight finish during CLEAR
      s1_rd   <= any_gnt && !win_we;
      s1_id   <= gnt1;
      s1_zero <= win_zero;
      s2_rd   <= s1_rd;
      s2_id   <= s1_id;
      s2_zero <= s1_zero;

      case (state)
        IDLE: begin
          if (clr_req) begin
            // The first clear write is presented together with clr_busy
            state        <= CLEAR;
            clr_busy     <= 1'b1;
            clr_cnt      <= CLR_FIRST;
            rf_write_en  <= 1'b1;
            rf_writereg  <= CLR_FIRST;
            rf_writedata <= '0;
          end else if (any_gnt) begin
            last_gnt <= gnt1;
            if (win_we) begin
              rf_write_en  <= !win_zero;
              rf_writereg  <= win_addr;
              rf_writedata <= win_wdata;
            end else begin
              rf_write_en  <= 1'b0;
              rf_readreg   <= win_addr;
            end
          end else begin
            rf_write_en <= 1'b0;
          end
        end

        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state       <= IDLE;
            clr_busy    <= 1'b0;
            clr_cnt     <= '0;
            rf_write_en <= 1'b0;
          end else begin
            clr_cnt      <= clr_cnt + ADDR_W'(1);
            rf_write_en  <= 1'b1;
            rf_writereg  <= clr_cnt + ADDR_W'(1);
            rf_writedata <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Read return routed to the owner of the stage-2 tag
  assign r0_rvalid = s2_rd && !s2_id;
  assign r1_rvalid = s2_rd &&  s2_id;
  assign r0_rdata  = (r0_rvalid && !s2_zero) ? rf_readdata : '0;
  assign r1_rdata  = (r1_rvalid && !s2_zero) ? rf_readdata : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: randomized and directed checks of regfile_arbiter against
// a cycle-level reference model of the arbitration, clear and read-return rules,
// with a behavioural register file attached to the rf_* port.
module tb_regfile_arbiter;

`ifdef REGFILE_ARB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_req;
  logic        clr_busy;
  logic        r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [3:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [3:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic [3:0]  rf_readreg, rf_writereg;
  logic [31:0] rf_writedata, rf_readdata;
  logic        rf_write_en;

  regfile_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .clr_busy(clr_busy),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .rf_readreg(rf_readreg), .rf_writereg(rf_writereg),
    .rf_writedata(rf_writedata), .rf_write_en(rf_write_en),
    .rf_readdata(rf_readdata)
  );

  always #5 clk = ~clk;

  // Register file: write lands before the same-edge read
  logic [31:0] rf_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'h0;
    rf_readdata = 32'h0;
  end
  always @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_writereg] = rf_writedata;
    rf_readdata <= rf_mem[rf_readreg];
  end

  // Reference model state
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rd_t;

  rd_t         rdq[$];
  logic [31:0] gold [16];
  int          cyc;
  int          n_checks;
  int          n_fail;
  bit          m_busy;
  int          m_clr_reg;
  int          m_last;
  bit          m_rst_chk;
  bit          m_gnt [2];
  logic        e_wen;
  logic [3:0]  e_wreg, e_rreg;
  logic [31:0] e_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int id, input logic we, input logic [3:0] addr, input logic [31:0] wd);
    if (id == 0) begin
      r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  task automatic drop(input int id);
    if (id == 0) r0_req = 1'b0;
    else         r1_req = 1'b0;
  endtask

  // Check the current cycle against the model, advance the model across the
  // closing edge, then step to just after that edge.
  task automatic tick();
    int          win;
    bit          ok;
    logic        ev [2];
    logic [31:0] ed [2];
    logic        wwe;
    logic [3:0]  waddr;
    logic [31:0] wwd;
    #1;
    ok  = !reset && !m_busy && !clr_req;
    win = -1;
    if (ok) begin
      if (r0_req && r1_req) win = 1 - m_last;
      else if (r0_req)      win = 0;
      else if (r1_req)      win = 1;
    end
    chk("r0_gnt", 32'(r0_gnt), 32'(win == 0));
    chk("r1_gnt", 32'(r1_gnt), 32'(win == 1));
    chk("clr_busy", 32'(clr_busy), 32'(m_busy));
    chk("rf_write_en", 32'(rf_write_en), 32'(e_wen));
    if (e_wen || m_rst_chk) begin
      chk("rf_writereg", 32'(rf_writereg), 32'(e_wreg));
      chk("rf_writedata", rf_writedata, e_wdata);
    end
    chk("rf_readreg", 32'(rf_readreg), 32'(e_rreg));

    ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = 32'h0; ed[1] = 32'h0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      ev[rdq[0].id] = 1'b1;
      ed[rdq[0].id] = rdq[0].data;
      void'(rdq.pop_front());
    end
    chk("r0_rvalid", 32'(r0_rvalid), 32'(ev[0]));
    chk("r0_rdata", r0_rdata, ed[0]);
    chk("r1_rvalid", 32'(r1_rvalid), 32'(ev[1]));
    chk("r1_rdata", r1_rdata, ed[1]);

    // The write presented this cycle lands at the closing edge, even under reset
    if (e_wen) gold[e_wreg] = e_wdata;
    m_gnt[0]  = (win == 0);
    m_gnt[1]  = (win == 1);
    m_rst_chk = 1'b0;

    if (reset) begin
      m_busy = 1'b0; m_last = 1; rdq.delete();
      e_wen = 1'b0; e_wreg = 4'h0; e_wdata = 32'h0; e_rreg = 4'h0;
      m_rst_chk = 1'b1;
    end else if (m_busy) begin
      if (m_clr_reg == 15) begin
        m_busy = 1'b0; e_wen = 1'b0;
      end else begin
        m_clr_reg++; e_wen = 1'b1; e_wreg = 4'(m_clr_reg); e_wdata = 32'h0;
      end
    end else if (clr_req) begin
      m_busy = 1'b1; m_clr_reg = 1; e_wen = 1'b1; e_wreg = 4'h1; e_wdata = 32'h0;
    end else if (win >= 0) begin
      wwe   = (win == 0) ? r0_we    : r1_we;
      waddr = (win == 0) ? r0_addr  : r1_addr;
      wwd   = (win == 0) ? r0_wdata : r1_wdata;
      m_last = win;
      if (wwe) begin
        e_wen = !(R0Z && waddr == 4'h0); e_wreg = waddr; e_wdata = wwd;
      end else begin
        e_wen = 1'b0; e_rreg = waddr;
        rdq.push_back('{cyc + 2, win, (R0Z && waddr == 4'h0) ? 32'h0 : gold[waddr]});
      end
    end else begin
      e_wen = 1'b0;
    end

    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_gnt(input int id, output int gcyc);
    gcyc = -1;
    for (int i = 0; i < 64; i++) begin
      int c;
      c = cyc;
      tick();
      if (m_gnt[id]) begin
        gcyc = c;
        return;
      end
    end
    chk("gnt_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int g, g1, c0, busy_n;
    bit rq [2];
    n_checks = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 16; i++) gold[i] = 32'h0;
    m_busy = 1'b0; m_clr_reg = 0; m_last = 1; m_rst_chk = 1'b0;
    e_wen = 1'b0; e_wreg = 4'h0; e_wdata = 32'h0; e_rreg = 4'h0;
    m_gnt[0] = 1'b0; m_gnt[1] = 1'b0;
    reset = 1'b1; clr_req = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 4'h0; r0_wdata = 32'h0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 4'h0; r1_wdata = 32'h0;
    @(posedge clk); #1;
    do_reset();

    // Write then read back address 5
    set_req(0, 1'b1, 4'd5, 32'hDEADBEEF);
    wait_gnt(0, g);
    set_req(0, 1'b0, 4'd5, 32'h0);
    wait_gnt(0, g1);
    chk("wr_rd_b2b", 32'(g1), 32'(g + 1));
    drop(0);
    idle(3);

    // Both reading continuously: strict alternation starting with r0
    do_reset();
    set_req(0, 1'b0, 4'($urandom_range(0, 15)), 32'h0);
    set_req(1, 1'b0, 4'($urandom_range(0, 15)), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alt_winner", 32'(m_gnt[1]), 32'(i % 2));
      for (int id = 0; id < 2; id++)
        if (m_gnt[id]) set_req(id, 1'b0, 4'($urandom_range(0, 15)), 32'h0);
    end
    drop(0); drop(1);
    idle(3);

    // Fill 0..15, then clear 1..15
    for (int a = 0; a < 16; a++) begin
      set_req(a % 2, 1'b1, 4'(a), (a == 0) ? 32'h0000_0F0F : 32'hA5A5A5A5);
      wait_gnt(a % 2, g);
      drop(a % 2);
    end
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (clr_busy) busy_n++;
      tick();
    end
    chk("clr_len", 32'(busy_n), 32'd15);
    for (int a = 0; a < 16; a++) begin
      set_req(1, 1'b0, 4'(a), 32'h0);
      wait_gnt(1, g);
    end
    drop(1);
    idle(3);

    // clr_req alongside a pending r1 write
    set_req(1, 1'b1, 4'd9, 32'h1357_9BDF);
    clr_req = 1'b1;
    c0 = cyc;
    tick();
    clr_req = 1'b0;
    wait_gnt(1, g);
    chk("r1_after_clr", 32'(g), 32'(c0 + 16));
    drop(1);
    idle(2);

    // Read in flight killed by reset
    set_req(0, 1'b0, 4'd9, 32'h0);
    wait_gnt(0, g);
    drop(0);
    do_reset();
    idle(3);

    // Reset at clear step 7
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 20 && !(m_busy && m_clr_reg == 7); i++) tick();
    chk("at_step7", 32'(clr_busy && rf_writereg == 4'd7), 32'h1);
    do_reset();
    idle(2);
    for (int a = 6; a < 10; a++) begin
      set_req(0, 1'b0, 4'(a), 32'h0);
      wait_gnt(0, g);
    end
    drop(0);
    idle(3);

    // Address 0 write and read
    set_req(0, 1'b1, 4'd0, 32'h0000_1234);
    wait_gnt(0, g);
    chk("r0z_wen", 32'(rf_write_en), 32'(!R0Z));
    set_req(1, 1'b0, 4'd0, 32'h0);
    drop(0);
    wait_gnt(1, g);
    drop(1);
    tick();
    chk("r0z_rdata", r1_rdata, R0Z ? 32'h0 : 32'h0000_1234);
    idle(2);

    // Random traffic with occasional clears and resets
    rq[0] = 1'b0; rq[1] = 1'b0;
    for (int i = 0; i < 600; i++) begin
      clr_req = ($urandom_range(0, 99) < 3);
      reset   = ($urandom_range(0, 199) < 2);
      tick();
      reset = 1'b0;
      for (int id = 0; id < 2; id++) begin
        if (!rq[id] || m_gnt[id]) begin
          if ($urandom_range(0, 99) < 65) begin
            set_req(id, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            rq[id] = 1'b1;
          end else begin
            drop(id);
            rq[id] = 1'b0;
          end
        end
      end
    end
    clr_req = 1'b0;
    drop(0); drop(1);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
